// File: rtl/qx1_pkg.sv
// Shared definitions for the QX1 memory arbiter: bus width defaults and FSM states.
package qx1_pkg;

  localparam int QX1_AW = 16;
  localparam int QX1_DW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/qx1_mem_arb_pick.sv
// Combinational two-way pick for the QX1 memory arbiter; produces one-hot grants.
module qx1_mem_arb_pick
  import qx1_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  arb_state_t state,
  input  logic       prio,
  output logic       gnt0,
  output logic       gnt1
);

  // A lock excludes the other port entirely; in IDLE a tie goes to the port named by prio.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          gnt0 = ~prio;
          gnt1 = prio;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
      LOCK0:   gnt0 = req0;
      LOCK1:   gnt1 = req1;
      default: ;
    endcase
  end

endmodule

// File: rtl/qx1_mem_arbiter.sv
// Two-port arbiter sharing the single-port QX1 memory, with lock support for atomic RMW.
// Define QX1_MEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module qx1_mem_arbiter
  import qx1_pkg::*;
#(
  parameter int AW = QX1_AW,
  parameter int DW = QX1_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p1_req,
  input  logic          p0_we,
  input  logic          p1_we,
  input  logic          p0_lock,
  input  logic          p1_lock,
  input  logic [AW-1:0] p0_addr,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic [DW-1:0] p1_wdata,
  output logic          p0_gnt,
  output logic          p1_gnt,
  output logic          p0_rvalid,
  output logic          p1_rvalid,
  output logic [DW-1:0] p0_rdata,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t state;
  logic       prio;
  logic       pick0;
  logic       pick1;

`ifndef QX1_MEM_ARB_RR_EN
  assign prio = 1'b0;
`endif

  qx1_mem_arb_pick u_pick (
    .req0  (p0_req),
    .req1  (p1_req),
    .state (state),
    .prio  (prio),
    .gnt0  (pick0),
    .gnt1  (pick1)
  );

  assign p0_gnt = pick0 & ~rst;
  assign p1_gnt = pick1 & ~rst;

  // Idle mux parks on port 0 with the write enable off.
  assign mem_addr  = p1_gnt ? p1_addr  : p0_addr;
  assign mem_wdata = p1_gnt ? p1_wdata : p0_wdata;
  assign mem_we    = p1_gnt ? p1_we    : (p0_gnt & p0_we);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
`ifdef QX1_MEM_ARB_RR_EN
      prio      <= 1'b0;
`endif
    end else begin
      // Capturing mem_rdata at the write edge yields the pre-write contents for swaps.
      p0_rvalid <= p0_gnt;
      p1_rvalid <= p1_gnt;
      if (p0_gnt) p0_rdata <= mem_rdata;
      if (p1_gnt) p1_rdata <= mem_rdata;

      case (state)
        IDLE: begin
          if (p0_gnt && p0_lock)      state <= LOCK0;
          else if (p1_gnt && p1_lock) state <= LOCK1;
        end
        LOCK0:   if (!p0_lock && (p0_gnt || !p0_req)) state <= IDLE;
        LOCK1:   if (!p1_lock && (p1_gnt || !p1_req)) state <= IDLE;
        default: state <= IDLE;
      endcase

`ifdef QX1_MEM_ARB_RR_EN
      if (state == IDLE) begin
        if (p0_gnt)      prio <= 1'b1;
        else if (p1_gnt) prio <= 1'b0;
      end
`endif
    end
  end

endmodule
